// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with store forwarding, lane alignment, misalignment squash and halt latch
module ex_mem_reg #(
  parameter int DATA_SIZE   = 32,
  parameter int REG_SIZE    = 5,
  parameter int SELECT_SIZE = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_flush,
  input  logic [DATA_SIZE-1:0]   i_alu_result,
  input  logic [DATA_SIZE-1:0]   i_data_b,
  input  logic [DATA_SIZE-1:0]   i_MEM_fwd_data,
  input  logic [DATA_SIZE-1:0]   i_WB_fwd_data,
  input  logic [SELECT_SIZE-1:0] i_forwarding_mux,
  input  logic [REG_SIZE-1:0]    i_rd,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  input  logic                   i_write_reg,
  input  logic                   i_mem_to_reg,
  input  logic                   i_unsigned,
  input  logic                   i_halt,
  input  logic [1:0]             i_bhw_type,
  output logic [DATA_SIZE-1:0]   o_alu_result,
  output logic [DATA_SIZE-1:0]   o_store_data,
  output logic [3:0]             o_byte_en,
  output logic [REG_SIZE-1:0]    o_rd,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_write_reg,
  output logic                   o_mem_to_reg,
  output logic                   o_unsigned,
  output logic                   o_halt,
  output logic [1:0]             o_bhw_type,
  output logic                   o_misaligned
);
  logic [DATA_SIZE-1:0] raw, aligned;
  logic [1:0] addr;
  logic [3:0] lanes;
  logic is_byte, is_half, mis;
  // store-data source select, lane replication/enables and alignment check; bhw 10 falls through as word
  always_comb begin
    raw = i_forwarding_mux == SELECT_SIZE'(0) ? i_MEM_fwd_data :
          i_forwarding_mux == SELECT_SIZE'(1) ? i_WB_fwd_data : i_data_b;
    addr = i_alu_result[1:0];
    is_byte = i_bhw_type == 2'b00;
    is_half = i_bhw_type == 2'b01;
    aligned = is_byte ? {(DATA_SIZE/8){raw[7:0]}} : is_half ? {(DATA_SIZE/16){raw[15:0]}} : raw;
    lanes = is_byte ? 4'b0001 << addr : is_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    mis = (i_mem_read || i_mem_write) && ((is_half && addr[0]) || (!is_byte && !is_half && addr != 2'b00));
  end
  // pipeline register: reset > flush / halt bubble (halt and sticky flag kept) > capture > hold
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_alu_result <= '0;
      o_store_data <= '0;
      o_byte_en    <= '0;
      o_rd         <= '0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_write_reg  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_unsigned   <= 1'b0;
      o_halt       <= 1'b0;
      o_bhw_type   <= '0;
      o_misaligned <= 1'b0;
    end else if (i_flush || (i_enable && o_halt)) begin
      o_alu_result <= '0;
      o_store_data <= '0;
      o_byte_en    <= '0;
      o_rd         <= '0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_write_reg  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_unsigned   <= 1'b0;
      o_bhw_type   <= '0;
    end else if (i_enable) begin
      o_alu_result <= i_alu_result;
      o_store_data <= aligned;
      o_byte_en    <= (i_mem_write && !mis) ? lanes : 4'b0000;
      o_rd         <= i_rd;
      o_mem_read   <= i_mem_read && !mis;
      o_mem_write  <= i_mem_write && !mis;
      o_write_reg  <= i_write_reg && !mis;
      o_mem_to_reg <= i_mem_to_reg;
      o_unsigned   <= i_unsigned;
      o_halt       <= i_halt;
      o_bhw_type   <= i_bhw_type;
      o_misaligned <= o_misaligned || mis;
    end
  end
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: randomized and directed checks of ex_mem_reg against a behavioural model
module tb_ex_mem_reg;
  logic i_clk = 1'b0, i_reset = 1'b0, i_enable = 1'b0, i_flush = 1'b0;
  logic [31:0] i_alu_result = '0, i_data_b = '0, i_MEM_fwd_data = '0, i_WB_fwd_data = '0;
  logic [1:0] i_forwarding_mux = '0, i_bhw_type = '0;
  logic [4:0] i_rd = '0;
  logic i_mem_read = 0, i_mem_write = 0, i_write_reg = 0, i_mem_to_reg = 0, i_unsigned = 0, i_halt = 0;
  logic [31:0] o_alu_result, o_store_data;
  logic [3:0] o_byte_en;
  logic [4:0] o_rd;
  logic o_mem_read, o_mem_write, o_write_reg, o_mem_to_reg, o_unsigned, o_halt, o_misaligned;
  logic [1:0] o_bhw_type;

  ex_mem_reg dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_alu_result(i_alu_result), .i_data_b(i_data_b), .i_MEM_fwd_data(i_MEM_fwd_data),
    .i_WB_fwd_data(i_WB_fwd_data), .i_forwarding_mux(i_forwarding_mux), .i_rd(i_rd),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_write_reg(i_write_reg),
    .i_mem_to_reg(i_mem_to_reg), .i_unsigned(i_unsigned), .i_halt(i_halt), .i_bhw_type(i_bhw_type),
    .o_alu_result(o_alu_result), .o_store_data(o_store_data), .o_byte_en(o_byte_en), .o_rd(o_rd),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_write_reg(o_write_reg),
    .o_mem_to_reg(o_mem_to_reg), .o_unsigned(o_unsigned), .o_halt(o_halt),
    .o_bhw_type(o_bhw_type), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] alu, sd;
    logic [3:0] be;
    logic [4:0] rd;
    logic mr, mw, wr, m2r, uns, halt;
    logic [1:0] bhw;
    logic mis;
  } st_t;

  st_t exp, saved;
  int compared = 0, mismatched = 0;

  function automatic st_t obs();
    return {o_alu_result, o_store_data, o_byte_en, o_rd, o_mem_read, o_mem_write, o_write_reg,
            o_mem_to_reg, o_unsigned, o_halt, o_bhw_type, o_misaligned};
  endfunction

  // next expected register contents from the current inputs, stated as access-size arithmetic
  function automatic st_t model(st_t cur);
    st_t n;
    int size, a;
    logic [31:0] raw;
    bit bad;
    if (i_flush || (i_enable && cur.halt)) begin
      n = '0;
      n.halt = cur.halt;
      n.mis = cur.mis;
    end else if (!i_enable) n = cur;
    else begin
      size = (i_bhw_type == 2'b00) ? 1 : (i_bhw_type == 2'b01) ? 2 : 4;
      a = int'(i_alu_result % 4);
      bad = (i_mem_read || i_mem_write) && (a % size != 0);
      raw = (i_forwarding_mux == 2'd0) ? i_MEM_fwd_data : (i_forwarding_mux == 2'd1) ? i_WB_fwd_data : i_data_b;
      n.alu = i_alu_result;
      n.sd = (size == 1) ? raw[7:0] * 32'h01010101 : (size == 2) ? raw[15:0] * 32'h00010001 : raw;
      n.be = (!i_mem_write || bad) ? 4'h0 : (size == 1) ? 4'(1 << a) : (size == 2) ? (a >= 2 ? 4'hC : 4'h3) : 4'hF;
      n.rd = i_rd;
      n.mr = i_mem_read && !bad;
      n.mw = i_mem_write && !bad;
      n.wr = i_write_reg && !bad;
      n.m2r = i_mem_to_reg;
      n.uns = i_unsigned;
      n.halt = i_halt;
      n.bhw = i_bhw_type;
      n.mis = cur.mis || bad;
    end
    return n;
  endfunction

  task automatic tick();
    exp = model(exp);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    {i_enable, i_flush, i_mem_read, i_mem_write, i_write_reg, i_mem_to_reg, i_unsigned, i_halt} = '0;
    {i_alu_result, i_data_b, i_MEM_fwd_data, i_WB_fwd_data} = '0;
    i_forwarding_mux = 2'b10;
    i_bhw_type = 2'b11;
    i_rd = '0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #2;
    i_reset = 1'b0;
    exp = '0;
  endtask

  task automatic test_reset();
    idle();
    i_reset = 1'b1;
    #3;
    compared++;
    if (obs() !== st_t'(0)) begin
      mismatched++;
      $display("FAIL reset_state: got %h expected 0", obs());
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    exp = '0;
  endtask

  task automatic test_word_store();
    idle();
    i_enable = 1; i_alu_result = 32'h100; i_data_b = 32'hDEADBEEF; i_mem_write = 1;
    tick();
    compared++;
    if (o_store_data !== 32'hDEADBEEF || o_byte_en !== 4'b1111 || o_alu_result !== 32'h100) begin
      mismatched++;
      $display("FAIL word_store: got sd=%h be=%b alu=%h expected deadbeef 1111 00000100", o_store_data, o_byte_en, o_alu_result);
    end
    compared++;
    if (obs() !== exp) begin
      mismatched++;
      $display("FAIL word_store_model: got %h expected %h", obs(), exp);
    end
  endtask

  task automatic test_fwd_byte();
    idle();
    i_enable = 1; i_forwarding_mux = 2'b00; i_MEM_fwd_data = 32'hA5; i_data_b = 32'h11223344;
    i_alu_result = 32'h102; i_bhw_type = 2'b00; i_mem_write = 1;
    tick();
    compared++;
    if (o_store_data !== 32'hA5A5A5A5 || o_byte_en !== 4'b0100) begin
      mismatched++;
      $display("FAIL fwd_mem_byte: got sd=%h be=%b expected a5a5a5a5 0100", o_store_data, o_byte_en);
    end
    i_forwarding_mux = 2'b01; i_WB_fwd_data = 32'h3C; i_alu_result = 32'h103;
    tick();
    compared++;
    if (o_store_data !== 32'h3C3C3C3C || o_byte_en !== 4'b1000) begin
      mismatched++;
      $display("FAIL fwd_wb_byte: got sd=%h be=%b expected 3c3c3c3c 1000", o_store_data, o_byte_en);
    end
    i_forwarding_mux = 2'b11; i_data_b = 32'h0000BEEF; i_alu_result = 32'h106; i_bhw_type = 2'b01;
    tick();
    compared++;
    if (o_store_data !== 32'hBEEFBEEF || o_byte_en !== 4'b1100) begin
      mismatched++;
      $display("FAIL half_store: got sd=%h be=%b expected beefbeef 1100", o_store_data, o_byte_en);
    end
  endtask

  task automatic test_misaligned();
    idle();
    i_enable = 1; i_alu_result = 32'h101; i_mem_read = 1; i_write_reg = 1; i_rd = 5'd7; i_mem_to_reg = 1;
    tick();
    compared++;
    if (o_mem_read !== 0 || o_write_reg !== 0 || o_rd !== 5'd7 || o_misaligned !== 1) begin
      mismatched++;
      $display("FAIL misaligned_load: got mr=%b wr=%b rd=%0d mis=%b expected 0 0 7 1", o_mem_read, o_write_reg, o_rd, o_misaligned);
    end
    i_alu_result = 32'h100;
    tick();
    compared++;
    if (o_mem_read !== 1 || o_misaligned !== 1) begin
      mismatched++;
      $display("FAIL misaligned_sticky: got mr=%b mis=%b expected 1 1", o_mem_read, o_misaligned);
    end
    compared++;
    if (obs() !== exp) begin
      mismatched++;
      $display("FAIL misaligned_model: got %h expected %h", obs(), exp);
    end
    do_reset();
  endtask

  task automatic test_stall_flush();
    idle();
    i_enable = 1; i_alu_result = 32'h204; i_mem_write = 1; i_data_b = 32'h12345678; i_rd = 5'd3;
    i_write_reg = 1; i_unsigned = 1;
    tick();
    saved = obs();
    i_enable = 0;
    for (int k = 0; k < 3; k++) begin
      i_alu_result = $urandom; i_data_b = $urandom; i_rd = 5'($urandom);
      tick();
      compared++;
      if (obs() !== saved) begin
        mismatched++;
        $display("FAIL stall_hold%0d: got %h expected %h", k, obs(), saved);
      end
    end
    i_flush = 1;
    tick();
    compared++;
    if (o_rd !== 0 || o_byte_en !== 0 || o_mem_read || o_mem_write || o_write_reg || o_mem_to_reg || o_unsigned || o_store_data !== 0) begin
      mismatched++;
      $display("FAIL flush_bubble: got %h expected bubble", obs());
    end
    i_flush = 0;
  endtask

  task automatic test_halt_reset();
    idle();
    i_enable = 1; i_halt = 1;
    tick();
    i_halt = 0; i_rd = 5'd5; i_write_reg = 1; i_alu_result = 32'h42;
    tick();
    compared++;
    if (o_halt !== 1 || o_rd !== 0 || o_write_reg !== 0) begin
      mismatched++;
      $display("FAIL halt_hold: got halt=%b rd=%0d wr=%b expected 1 0 0", o_halt, o_rd, o_write_reg);
    end
    #2;
    i_reset = 1;
    #1;
    compared++;
    if (obs() !== st_t'(0)) begin
      mismatched++;
      $display("FAIL async_reset: got %h expected 0", obs());
    end
    i_reset = 0;
    exp = '0;
    tick();
    compared++;
    if (o_rd !== 5'd5 || o_write_reg !== 1 || o_halt !== 0) begin
      mismatched++;
      $display("FAIL resume_after_reset: got rd=%0d wr=%b halt=%b expected 5 1 0", o_rd, o_write_reg, o_halt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      i_enable = $urandom_range(3) != 0;
      i_flush = $urandom_range(15) == 0;
      i_alu_result = $urandom; i_data_b = $urandom; i_MEM_fwd_data = $urandom; i_WB_fwd_data = $urandom;
      i_forwarding_mux = 2'($urandom); i_bhw_type = 2'($urandom); i_rd = 5'($urandom);
      i_mem_read = $urandom_range(1); i_mem_write = $urandom_range(1); i_write_reg = $urandom_range(1);
      i_mem_to_reg = $urandom_range(1); i_unsigned = $urandom_range(1);
      i_halt = $urandom_range(39) == 0;
      tick();
      compared++;
      if (obs() !== exp) begin
        mismatched++;
        $display("FAIL random%0d: got %h expected %h", k, obs(), exp);
      end
      if ($urandom_range(29) == 0) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_fwd_byte();
    test_misaligned();
    test_stall_flush();
    test_halt_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
